// File: rtl/key_entry_ctrl_if.sv
// Keypad-to-entry-buffer bundle: qualified key inputs in, digit buffer and status out.
// The master drives the scanner-side inputs; the slave is the entry controller.
interface key_entry_ctrl_if;
  logic        tick;
  logic        key_valid;
  logic [3:0]  key;
  logic        lock;
  logic [3:0]  q0;
  logic [3:0]  q1;
  logic [3:0]  q2;
  logic [3:0]  q3;
  logic [2:0]  count;
  logic        full;
  logic [15:0] value;
  logic        commit;
  logic        err;

  modport master (
    output tick, key_valid, key, lock,
    input  q0, q1, q2, q3, count, full, value, commit, err
  );

  modport slave (
    input  tick, key_valid, key, lock,
    output q0, q1, q2, q3, count, full, value, commit, err
  );
endinterface

// File: rtl/key_entry_ctrl.sv
// Debounces scanned keys and turns each accepted press into one edit of a 4-digit
// entry buffer (shift-in, backspace, clear, enter/commit).
module key_entry_ctrl #(
  parameter int unsigned STABLE_CNT = 3,
  parameter logic [3:0]  BLANK      = 4'hF
) (
  input logic             clk,
  input logic             rst,
  key_entry_ctrl_if.slave kif
);

  typedef enum logic [1:0] {StIdle, StDebounce, StAction, StWaitRel} state_e;

  localparam logic [3:0] StableCnt = 4'(STABLE_CNT);

  state_e      r_state;
  logic [3:0]  r_cand;
  logic [3:0]  r_stab;
  logic [3:0]  r_rel;
  logic [3:0]  r_q0;
  logic [3:0]  r_q1;
  logic [3:0]  r_q2;
  logic [3:0]  r_q3;
  logic [2:0]  r_count;
  logic [15:0] r_value;
  logic        r_commit;
  logic        r_err;

  logic [3:0]  w_stab_nxt;
  logic [3:0]  w_rel_nxt;
  logic [15:0] w_commit_val;

  function automatic logic [3:0] unblank(input logic [3:0] d);
    return (d == BLANK) ? 4'h0 : d;
  endfunction

  assign w_stab_nxt   = r_stab + 4'd1;
  assign w_rel_nxt    = r_rel + 4'd1;
  assign w_commit_val = {unblank(r_q3), unblank(r_q2), unblank(r_q1), unblank(r_q0)};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= StIdle;
      r_cand   <= 4'h0;
      r_stab   <= 4'd0;
      r_rel    <= 4'd0;
      r_q0     <= BLANK;
      r_q1     <= BLANK;
      r_q2     <= BLANK;
      r_q3     <= BLANK;
      r_count  <= 3'd0;
      r_value  <= 16'h0000;
      r_commit <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_commit <= 1'b0;
      r_err    <= 1'b0;
      case (r_state)
        StIdle: begin
          if (kif.tick && kif.key_valid) begin
            r_cand  <= kif.key;
            r_stab  <= 4'd1;
            r_state <= (StableCnt == 4'd1) ? StAction : StDebounce;
          end
        end
        StDebounce: begin
          if (kif.tick) begin
            if (!kif.key_valid || (kif.key != r_cand)) begin
              r_state <= StIdle;
            end else begin
              r_stab <= w_stab_nxt;
              if (w_stab_nxt == StableCnt) r_state <= StAction;
            end
          end
        end
        StAction: begin
          // One clk only; any tick arriving here is intentionally dropped.
          r_state <= StWaitRel;
          r_rel   <= 4'd0;
          if (kif.lock && (r_cand != 4'hA)) begin
            r_err <= 1'b1;
          end else if (r_cand <= 4'd9) begin
            if (r_count < 3'd4) begin
              r_q3    <= r_q2;
              r_q2    <= r_q1;
              r_q1    <= r_q0;
              r_q0    <= r_cand;
              r_count <= r_count + 3'd1;
            end else begin
              r_err <= 1'b1;
            end
          end else begin
            case (r_cand)
              4'hA: begin
                r_q0    <= BLANK;
                r_q1    <= BLANK;
                r_q2    <= BLANK;
                r_q3    <= BLANK;
                r_count <= 3'd0;
              end
              4'hB: begin
                if (r_count != 3'd0) begin
                  r_q0    <= r_q1;
                  r_q1    <= r_q2;
                  r_q2    <= r_q3;
                  r_q3    <= BLANK;
                  r_count <= r_count - 3'd1;
                end else begin
                  r_err <= 1'b1;
                end
              end
              4'hC: begin
                if (r_count != 3'd0) begin
                  r_value  <= w_commit_val;
                  r_commit <= 1'b1;
                  r_q0     <= BLANK;
                  r_q1     <= BLANK;
                  r_q2     <= BLANK;
                  r_q3     <= BLANK;
                  r_count  <= 3'd0;
                end else begin
                  r_err <= 1'b1;
                end
              end
              default: r_err <= 1'b1;
            endcase
          end
        end
        StWaitRel: begin
          if (kif.tick) begin
            if (kif.key_valid) begin
              r_rel <= 4'd0;
            end else if (w_rel_nxt == StableCnt) begin
              r_state <= StIdle;
            end else begin
              r_rel <= w_rel_nxt;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign kif.q0     = r_q0;
  assign kif.q1     = r_q1;
  assign kif.q2     = r_q2;
  assign kif.q3     = r_q3;
  assign kif.count  = r_count;
  assign kif.full   = (r_count == 3'd4);
  assign kif.value  = r_value;
  assign kif.commit = r_commit;
  assign kif.err    = r_err;

endmodule
